// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM states, widths.
// Opcode values are also reused by the ALU test tree.
package alu_sequencer_pkg;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;
    localparam int CNT_W   = 4;

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // True when the op needs at least one ITER step after EXEC.
    function automatic logic op_iterates(input logic [2:0] op, input logic [SHAMT_W-1:0] shamt);
        return (op == OP_MUL) || (((op == OP_SLL) || (op == OP_SRL)) && (shamt != '0));
    endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// Accumulator, multiplicand/multiplier and step counter for the ALU sequencer.
// Latency: load or step updates registers at the next edge; acc_nxt is the combinational preview.
// Backpressure: none, driven purely by load/step strobes from the sequencer FSM.
module alu_seq_datapath
    import alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             err_nxt,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             err;
    logic [WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        err_nxt    = err;
        if (load) begin
            err_nxt = 1'b0;
            cnt_nxt = '0;
            case (op)
                OP_FWD: acc_nxt = data2;
                OP_ADD: acc_nxt = data1 + data2;
                OP_AND: acc_nxt = data1 & data2;
                OP_OR:  acc_nxt = data1 | data2;
                OP_MUL: begin
                    acc_nxt    = '0;
                    mcand_nxt  = data1;
                    mplier_nxt = data2;
                    cnt_nxt    = CNT_W'(WIDTH);
                end
                OP_SLL, OP_SRL: begin
                    acc_nxt = data1;
                    cnt_nxt = CNT_W'(data2[SHAMT_W-1:0]);
                end
                default: begin
                    acc_nxt = '0;
                    err_nxt = 1'b1;
                end
            endcase
        end else if (step) begin
            cnt_nxt = cnt - CNT_W'(1);
            case (op)
                OP_MUL: begin
                    // Shift-and-add; carries out of bit 7 are dropped.
                    if (mplier[0])
                        acc_nxt = acc + mcand;
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                end
                OP_SLL:  acc_nxt = acc << 1;
                OP_SRL:  acc_nxt = acc >> 1;
                default: acc_nxt = acc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: start handshake, operand latch, FSM and registered result.
// Latency: 2 cycles for single-step ops, 2+n for shifts by n, 10 for MUL.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             error
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] d2_q;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] acc_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt;

    alu_seq_datapath u_datapath (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .op      (op_q),
        .data1   (d1_q),
        .data2   (d2_q),
        .acc_nxt (acc_nxt),
        .err_nxt (err_nxt),
        .cnt     (cnt)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_EXEC;
            S_EXEC: begin
                load      = 1'b1;
                state_nxt = op_iterates(op_q, d2_q[SHAMT_W-1:0]) ? S_ITER : S_FIN;
            end
            S_ITER: begin
                step = 1'b1;
                // Counter hits zero after this step.
                if (cnt == CNT_W'(1))
                    state_nxt = S_FIN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            result <= '0;
            zero   <= 1'b1;
            error  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                op_q <= opcode;
                d1_q <= data1;
                d2_q <= data2;
            end
            // Outputs capture the accumulator's final value on the edge entering FIN.
            if (state_nxt == S_FIN) begin
                result <= acc_nxt;
                zero   <= (acc_nxt == '0);
                error  <= err_nxt;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: arithmetic reference model plus directed vectors.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       error;

    alu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .data1  (data1),
        .data2  (data2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .error  (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: one outstanding op, issued at edge count m_t0.
    bit         chk_en = 1'b0;
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    int         m_L = 0;
    logic [7:0] m_res = 8'h00;
    bit         m_err = 1'b0;
    logic [7:0] held_res = 8'h00;
    bit         held_zero = 1'b1;
    bit         held_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] r, output bit e, output int L);
        int n;
        n = int'(b) % 8;
        e = 1'b0;
        L = 2;
        case (op)
            OP_FWD: r = b;
            OP_ADD: r = 8'((int'(a) + int'(b)) % 256);
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_MUL: begin r = 8'((int'(a) * int'(b)) % 256); L = 10; end
            OP_SLL: begin r = 8'((int'(a) * (1 << n)) % 256); L = 2 + n; end
            OP_SRL: begin r = 8'(int'(a) / (1 << n)); L = 2 + n; end
            default: begin r = 8'h00; e = 1'b1; end
        endcase
    endfunction

    function automatic void model_clear();
        m_active  = 1'b0;
        held_res  = 8'h00;
        held_zero = 1'b1;
        held_err  = 1'b0;
    endfunction

    // Per-cycle compare: period k after issue edge is cycle k+1 of the op.
    always @(negedge clk) begin : compare
        bit exp_busy;
        bit exp_done;
        int k;
        if (chk_en) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (m_active) begin
                k = cyc - m_t0;
                if (k >= 0 && k <= m_L - 1) exp_busy = 1'b1;
                if (k == m_L - 1) begin
                    exp_done  = 1'b1;
                    held_res  = m_res;
                    held_err  = m_err;
                    held_zero = (m_res == 8'h00);
                end
                if (k >= m_L - 1) m_active = 1'b0;
            end
            check("busy",   32'(busy),   32'(exp_busy));
            check("done",   32'(done),   32'(exp_done));
            check("result", 32'(result), 32'(held_res));
            check("zero",   32'(zero),   32'(held_zero));
            check("error",  32'(error),  32'(held_err));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        start  = 1'b1;
        opcode = op;
        data1  = a;
        data2  = b;
        @(posedge clk);
        #1;
        m_t0 = cyc;
        model_op(op, a, b, m_res, m_err, m_L);
        m_active = 1'b1;
    endtask

    // Issues one op and returns at the negedge of its DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input int exp_L, input bit exp_err,
                          input bit repulse, input bit skip_sync, input string tag);
        if (!skip_sync) @(negedge clk);
        issue(op, a, b);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_model_L"},   32'(m_L),   32'(exp_L));
        check({tag, "_model_res"}, 32'(m_res), 32'(exp_res));
        for (int k = 1; k <= exp_L - 1; k++) begin
            @(negedge clk);
            if (repulse && (k == 2 || k == 8)) begin
                start  = 1'b1;
                opcode = OP_ADD;
                data1  = 8'd1;
                data2  = 8'd1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_done"},   32'(done),   32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_zero"},   32'(zero),   32'(exp_res == 8'h00));
        check({tag, "_error"},  32'(error),  32'(exp_err));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 3'b000;
        data1  = 8'h00;
        data2  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero",   32'(zero),   32'd1);
        reset = 1'b0;

        run_op(OP_ADD, 8'd25,  8'd34, 8'd59,  2,  1'b0, 1'b0, 1'b0, "add_25_34");
        run_op(OP_ADD, 8'd200, 8'd56, 8'd0,   2,  1'b0, 1'b0, 1'b0, "add_wrap");
        run_op(OP_AND, 8'hF0,  8'h3C, 8'h30,  2,  1'b0, 1'b0, 1'b0, "and");
        run_op(OP_OR,  8'hF0,  8'h0C, 8'hFC,  2,  1'b0, 1'b0, 1'b0, "or");
        run_op(OP_MUL, 8'd13,  8'd11, 8'd143, 10, 1'b0, 1'b0, 1'b0, "mul_13_11");
        run_op(OP_MUL, 8'd20,  8'd20, 8'd144, 10, 1'b0, 1'b0, 1'b0, "mul_20_20");
        run_op(OP_MUL, 8'd0,   8'd77, 8'd0,   10, 1'b0, 1'b0, 1'b0, "mul_0_77");
        run_op(OP_SLL, 8'h81,  8'd3,  8'h08,  5,  1'b0, 1'b0, 1'b0, "sll_3");
        run_op(OP_SRL, 8'h81,  8'd7,  8'h01,  9,  1'b0, 1'b0, 1'b0, "srl_7");
        run_op(OP_SRL, 8'h81,  8'd0,  8'h81,  2,  1'b0, 1'b0, 1'b0, "srl_0");
        run_op(OP_RSVD, 8'd5,  8'd9,  8'd0,   2,  1'b1, 1'b0, 1'b0, "rsvd");
        run_op(OP_FWD, 8'd7,   8'd34, 8'd34,  2,  1'b0, 1'b0, 1'b0, "fwd_after_rsvd");
        run_op(OP_MUL, 8'd13,  8'd11, 8'd143, 10, 1'b0, 1'b1, 1'b0, "mul_repulse");

        // Reset mid-ITER: asserted in cycle 5, outputs at reset values from cycle 6.
        @(negedge clk);
        issue(OP_MUL, 8'd13, 8'd11);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zero",   32'(zero),   32'd1);
        reset = 1'b0;
        run_op(OP_FWD, 8'd0, 8'd25, 8'd25, 2, 1'b0, 1'b0, 1'b1, "fwd_after_rst");

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset  = 1'b1;
        start  = 1'b1;
        opcode = OP_FWD;
        data2  = 8'd5;
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        check("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", 32'(busy), 32'd0);

        run_op(OP_SLL, 8'h01, 8'd7, 8'h80, 9, 1'b0, 1'b0, 1'b0, "sll_7");
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
